// File: rtl/arp_tx.sv
// arp_tx: serialises one Ethernet II / ARP request or reply frame onto GMII, one byte per clock.
// Latency: first preamble byte one clock after the accepted start pulse; 72 bytes, then tx_done.
// Backpressure: none; start pulses while busy are dropped, IFG_CYCLES idle cycles follow every frame.
module arp_tx #(
  parameter logic [47:0] BOARD_MAC  = 48'h00_0a_35_01_fe_c0,
  parameter logic [31:0] BOARD_IP   = 32'hC0_A8_00_02,
  parameter int          IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_tx_en,
  input  logic        arp_tx_type,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    ETH_HEAD = 3'd2,
    ARP_DATA = 3'd3,
    FCS      = 3'd4,
    IFG      = 3'd5
  } state_t;

  // Last counter value of each state (counter restarts at 0 on every state change).
  localparam logic [5:0] PRE_LAST = 6'd7;
  localparam logic [5:0] ETH_LAST = 6'd13;
  localparam logic [5:0] ARP_LAST = 6'd45;   // 28 ARP bytes + 18 pad bytes
  localparam logic [5:0] FCS_LAST = 6'd3;
  localparam logic [5:0] IFG_LAST = 6'(IFG_CYCLES - 1);

  state_t      state, next_state;
  logic [5:0]  cnt;

  // Frame parameters captured at the start pulse so later input changes cannot corrupt the frame.
  logic        lat_type;
  logic [47:0] lat_mac;
  logic [31:0] lat_ip;

  logic [31:0] crc_reg;
  logic [31:0] fcs;
  logic [7:0]  tx_byte;
  logic        tx_vld;
  logic        crc_upd;
  logic        done_nxt;
  logic        busy_nxt;

  // Byte i (0 = most significant) of a MAC address.
  function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [5:0] i);
    logic [47:0] s;
    s = m << (8 * i);
    return s[47:40];
  endfunction

  // Byte i (0 = most significant) of an IPv4 address.
  function automatic logic [7:0] ip_byte(input logic [31:0] a, input logic [5:0] i);
    logic [31:0] s;
    s = a << (8 * i);
    return s[31:24];
  endfunction

  // Reflected CRC32 advanced by one byte, data consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign fcs = ~crc_reg;

  // State register and per-state byte counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if ((next_state != state) || (state == IDLE))
        cnt <= '0;
      else
        cnt <= cnt + 6'd1;
    end
  end

  // Next-state: each frame section advances when its counter reaches the last byte.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (arp_tx_en)       next_state = PREAMBLE;
      PREAMBLE: if (cnt == PRE_LAST) next_state = ETH_HEAD;
      ETH_HEAD: if (cnt == ETH_LAST) next_state = ARP_DATA;
      ARP_DATA: if (cnt == ARP_LAST) next_state = FCS;
      FCS:      if (cnt == FCS_LAST) next_state = IFG;
      IFG:      if (cnt == IFG_LAST) next_state = IDLE;
      default:                       next_state = IDLE;
    endcase
  end

  // Output decode: the byte to present next, whether it is a frame byte and whether it feeds the CRC.
  always_comb begin
    tx_byte = 8'h00;
    tx_vld  = 1'b0;
    crc_upd = 1'b0;
    case (state)
      PREAMBLE: begin
        tx_vld  = 1'b1;
        tx_byte = (cnt == PRE_LAST) ? 8'hD5 : 8'h55;
      end
      ETH_HEAD: begin
        tx_vld  = 1'b1;
        crc_upd = 1'b1;
        if (cnt < 6'd6)
          tx_byte = lat_type ? mac_byte(lat_mac, cnt) : 8'hFF;
        else if (cnt < 6'd12)
          tx_byte = mac_byte(BOARD_MAC, cnt - 6'd6);
        else if (cnt == 6'd12)
          tx_byte = 8'h08;
        else
          tx_byte = 8'h06;
      end
      ARP_DATA: begin
        tx_vld  = 1'b1;
        crc_upd = 1'b1;
        if (cnt == 6'd1)
          tx_byte = 8'h01;                                  // HTYPE = Ethernet
        else if (cnt == 6'd2)
          tx_byte = 8'h08;                                  // PTYPE = IPv4
        else if (cnt == 6'd4)
          tx_byte = 8'h06;                                  // HLEN
        else if (cnt == 6'd5)
          tx_byte = 8'h04;                                  // PLEN
        else if (cnt == 6'd7)
          tx_byte = lat_type ? 8'h02 : 8'h01;               // OPER low byte
        else if ((cnt >= 6'd8) && (cnt < 6'd14))
          tx_byte = mac_byte(BOARD_MAC, cnt - 6'd8);        // SHA
        else if ((cnt >= 6'd14) && (cnt < 6'd18))
          tx_byte = ip_byte(BOARD_IP, cnt - 6'd14);         // SPA
        else if ((cnt >= 6'd18) && (cnt < 6'd24))
          tx_byte = lat_type ? mac_byte(lat_mac, cnt - 6'd18) : 8'h00;  // THA
        else if ((cnt >= 6'd24) && (cnt < 6'd28))
          tx_byte = ip_byte(lat_ip, cnt - 6'd24);           // TPA
        else
          tx_byte = 8'h00;                                  // zero bytes and pad
      end
      FCS: begin
        tx_vld = 1'b1;
        case (cnt[1:0])
          2'd0:    tx_byte = fcs[7:0];
          2'd1:    tx_byte = fcs[15:8];
          2'd2:    tx_byte = fcs[23:16];
          default: tx_byte = fcs[31:24];
        endcase
      end
      default: begin
        tx_byte = 8'h00;
        tx_vld  = 1'b0;
      end
    endcase
  end

  // Registered-output next values: done in the first IFG cycle, busy whenever not idle.
  always_comb begin
    done_nxt = (state == IFG) && (cnt == 6'd0);
    busy_nxt = (state != IDLE);
  end

  // Capture frame parameters on an accepted start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_type <= 1'b0;
      lat_mac  <= '0;
      lat_ip   <= '0;
    end else if ((state == IDLE) && arp_tx_en) begin
      lat_type <= arp_tx_type;
      lat_mac  <= des_mac;
      lat_ip   <= des_ip;
    end
  end

  // CRC register: seeded during the preamble, advanced on every header/body/pad byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      crc_reg <= 32'hFFFF_FFFF;
    else if (state == PREAMBLE)
      crc_reg <= 32'hFFFF_FFFF;
    else if (crc_upd)
      crc_reg <= crc32_byte(crc_reg, tx_byte);
  end

  // Registered GMII and status outputs; txd forced to zero outside the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gmii_tx_en <= 1'b0;
      gmii_txd   <= 8'h00;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      gmii_tx_en <= tx_vld;
      gmii_txd   <= tx_vld ? tx_byte : 8'h00;
      busy       <= busy_nxt;
      tx_done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_arp_tx.sv
// tb_arp_tx: randomized start pulses against a frame-level reference model.
// Expected frames and timing are queued at stimulus time; a negedge monitor pops and compares.
module tb_arp_tx;

  localparam int          IFG  = 12;
  localparam logic [47:0] BMAC = 48'h000A3501FEC0;
  localparam logic [31:0] BIP  = 32'hC0A80002;

  logic        clk = 1'b0;
  logic        rst;
  logic        arp_tx_en;
  logic        arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        busy;
  logic        tx_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;   // index of the most recent rising edge

  // Reference-model state, written by the stimulus, read by the monitor.
  logic [7:0] exp_q[$];
  int         start_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] fr[$];
  int         busy_lo   = 0;
  int         busy_hi   = -1;
  int         exp_done  = -1;
  int         next_free = 0;
  int         last_e    = 0;

  arp_tx #(.BOARD_MAC(BMAC), .BOARD_IP(BIP), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .rst(rst), .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
    .des_mac(des_mac), .des_ip(des_ip), .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
    .busy(busy), .tx_done(tx_done)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-serial reflected CRC32 step.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic put(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fr.push_back(v[8*i +: 8]);
  endtask

  // Assemble the complete expected frame from its fields and queue it.
  task automatic build_frame(input logic t, input logic [47:0] m, input logic [31:0] ip);
    logic [31:0] c;
    fr.delete();
    put(48'h555555555555, 6);
    put(48'h55D5, 2);
    put(t ? m : 48'hFFFFFFFFFFFF, 6);
    put(BMAC, 6);
    put(48'h0806, 2);
    put(48'h0001, 2);
    put(48'h0800, 2);
    put(48'h06, 1);
    put(48'h04, 1);
    put(t ? 48'h2 : 48'h1, 2);
    put(BMAC, 6);
    put(BIP, 4);
    put(t ? m : 48'h0, 6);
    put(ip, 4);
    for (int i = 0; i < 18; i++) put(48'h0, 1);
    c = 32'hFFFFFFFF;
    for (int i = 8; i < 68; i++) c = crc_upd(c, fr[i]);
    c = ~c;
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    fr.push_back(c[23:16]);
    fr.push_back(c[31:24]);
    foreach (fr[i]) exp_q.push_back(fr[i]);
  endtask

  // Called at a negedge: drives a one-cycle start pulse sampled by the next rising edge.
  task automatic pulse(input logic t, input logic [47:0] m, input logic [31:0] ip);
    int e;
    #1;
    arp_tx_type = t;
    des_mac     = m;
    des_ip      = ip;
    arp_tx_en   = 1'b1;
    e = cyc + 1;
    if (!rst && e >= next_free) begin
      build_frame(t, m, ip);
      start_q.push_back(e + 1);
      busy_lo   = e + 1;
      busy_hi   = e + 72 + IFG;
      exp_done  = e + 73;
      next_free = e + 73 + IFG;
      last_e    = e;
    end
    @(negedge clk);
    arp_tx_en   = 1'b0;
    des_mac     = 48'({$urandom, $urandom});
    des_ip      = $urandom;
    arp_tx_type = 1'($urandom);
  endtask

  // Advance (at negedges) so that a pulse issued now is sampled by edge e.
  task automatic go_to(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 400, 1);
  endtask

  // Monitor: compares every cycle's outputs against the model, frame bytes against the queue.
  always @(negedge clk) begin
    logic [31:0] r, rev;
    if (rst) begin
      chk("rst_tx_en", gmii_tx_en, 0);
      chk("rst_txd", gmii_txd, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_done", tx_done, 0);
      rx_q.delete();
    end else begin
      chk("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
      chk("tx_done", tx_done, cyc == exp_done);
      if (gmii_tx_en) begin
        if (rx_q.size() == 0) begin
          chk("frame_expected", start_q.size() > 0, 1);
          if (start_q.size() > 0) chk("frame_start_cycle", cyc, start_q.pop_front());
        end
        chk("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0)
          chk($sformatf("byte%0d", rx_q.size() + 1), gmii_txd, exp_q.pop_front());
        rx_q.push_back(gmii_txd);
      end else begin
        chk("idle_txd", gmii_txd, 0);
        if (rx_q.size() > 0) begin
          chk("frame_len", rx_q.size(), 72);
          // CRC over header..FCS: the reflected register's bit-reverse is the CRC32 residue.
          r = 32'hFFFFFFFF;
          for (int i = 8; i < rx_q.size(); i++) r = crc_upd(r, rx_q[i]);
          for (int i = 0; i < 32; i++) rev[i] = r[31-i];
          chk("fcs_residue", rev, 32'hC704DD7B);
          rx_q.delete();
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst = 1'b1; arp_tx_en = 1'b0; arp_tx_type = 1'b0; des_mac = '0; des_ip = '0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Request, with stray pulses at E10 and E40 that must be dropped.
    pulse(1'b0, 48'hA1B2C3D4E5F6, 32'hC0A80003);
    e0 = last_e;
    go_to(e0 + 10); pulse(1'b1, 48'h0, 32'h0);
    go_to(e0 + 40); pulse(1'b1, 48'h0, 32'h0);
    // Reply issued exactly on the busy-falling edge.
    go_to(next_free);
    pulse(1'b1, 48'h112233445566, 32'hC0A80001);
    wait_idle();

    // Randomized traffic: back-to-back, late, and dropped early pulses.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: go_to(next_free);
        1: repeat ($urandom_range(0, 30)) @(negedge clk);
        2: go_to(next_free + $urandom_range(0, 5));
        default: repeat ($urandom_range(1, 90)) @(negedge clk);
      endcase
      pulse(1'($urandom), 48'({$urandom, $urandom}), $urandom);
    end
    wait_idle();

    // Reset while byte 30 is on the wire, then a clean frame.
    go_to(next_free);
    pulse(1'b1, 48'({$urandom, $urandom}), $urandom);
    while (cyc < last_e + 30) @(negedge clk);
    chk("pre_rst_tx_en", gmii_tx_en, 1);
    #1 rst = 1'b1;
    exp_q.delete(); start_q.delete();
    busy_hi = -1; exp_done = -1; next_free = 0;
    #1;
    chk("rst_async_tx_en", gmii_tx_en, 0);
    chk("rst_async_busy", busy, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    pulse(1'b0, 48'({$urandom, $urandom}), 32'hC0A800FE);
    wait_idle();
    repeat (5) @(negedge clk);

    chk("exp_queue_empty", exp_q.size(), 0);
    chk("start_queue_empty", start_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
